// File: rtl/vgachargen_pkg.sv
// Shared vgachargen parameters, region decode type and
// the character-table byte-merge helper.
package vgachargen_pkg;

  localparam int CH_T_ADDR_WIDTH = 7;
  localparam int CH_T_DATA_WIDTH = 128;
  localparam int CH_T_ENTRIES    = 2 ** CH_T_ADDR_WIDTH;

  localparam int MAP_WORDS  = 600;
  localparam int CH_T_WORDS = CH_T_DATA_WIDTH / 32;
  localparam int CH_T_WIDX_W =
    (CH_T_WORDS > 1) ? $clog2(CH_T_WORDS) : 1;

  typedef enum logic [1:0] {
    REG_CH_MAP,
    REG_COL_MAP,
    REG_CH_T,
    REG_RSVD
  } region_e;

  // Overlay the strobed bytes of wdata onto one 32-bit
  // word of a character-table entry.
  function automatic logic [CH_T_DATA_WIDTH-1:0] merge_word(
    input logic [CH_T_DATA_WIDTH-1:0] entry,
    input logic [CH_T_WIDX_W-1:0]     word_idx,
    input logic [31:0]                wdata,
    input logic [3:0]                 strb
  );
    logic [CH_T_DATA_WIDTH-1:0] res;
    res = entry;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[int'(word_idx)*32 + b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_vgachargen_bridge.sv
// APB3 responder mapping bus transfers onto the vgachargen
// character map, colour map and character table ports.
module apb_vgachargen_bridge
  import vgachargen_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 14,
  parameter int RD_LATENCY     = 1
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_rst_i,
  input  logic                       apb_psel_i,
  input  logic                       apb_penable_i,
  input  logic                       apb_pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0]  apb_paddr_i,
  input  logic [31:0]                apb_pwdata_i,
  input  logic [3:0]                 apb_pstrb_i,
  output logic                       apb_pready_o,
  output logic [31:0]                apb_prdata_o,
  output logic                       apb_pslverr_o,
  output logic [9:0]                 ch_map_addr_o,
  output logic [31:0]                ch_map_data_o,
  output logic [3:0]                 ch_map_wen_o,
  input  logic [31:0]                ch_map_data_i,
  output logic [9:0]                 col_map_addr_o,
  output logic [31:0]                col_map_data_o,
  output logic [3:0]                 col_map_wen_o,
  input  logic [31:0]                col_map_data_i,
  output logic [CH_T_ADDR_WIDTH-1:0] ch_t_rw_addr_o,
  output logic [CH_T_DATA_WIDTH-1:0] ch_t_rw_data_o,
  output logic                       ch_t_rw_wen_o,
  input  logic [CH_T_DATA_WIDTH-1:0] ch_t_rw_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RESP
  } state_e;

  state_e                 r_state;
  region_e                r_region;
  logic                   r_write;
  logic [31:0]            r_wdata;
  logic [3:0]             r_strb;
  logic [CH_T_WIDX_W-1:0] r_word;
  logic [1:0]             r_cnt;
  logic                   r_pready;
  logic                   r_pslverr;
  logic [31:0]            r_prdata;

  logic [9:0]             w_off;
  logic [9:0]             w_entry;
  logic [CH_T_WIDX_W-1:0] w_word;
  region_e                w_reg;
  logic                   w_legal;
  logic                   w_setup;
  logic                   w_unused;

  assign w_off   = apb_paddr_i[11:2];
  assign w_reg   = region_e'(apb_paddr_i[13:12]);
  assign w_entry = w_off / 10'(CH_T_WORDS);
  assign w_word  = CH_T_WIDX_W'(w_off % 10'(CH_T_WORDS));
  assign w_setup = apb_psel_i & ~apb_penable_i;
  assign w_unused = ^apb_paddr_i;

  assign apb_pready_o  = r_pready;
  assign apb_pslverr_o = r_pslverr;
  assign apb_prdata_o  = r_prdata;

  // Offset legality per region; reserved region never legal.
  always_comb begin
    w_legal = 1'b0;
    unique case (w_reg)
      REG_CH_MAP,
      REG_COL_MAP: w_legal = (w_off < 10'(MAP_WORDS));
      REG_CH_T:    w_legal = (w_entry < 10'(CH_T_ENTRIES));
      default:     w_legal = 1'b0;
    endcase
  end

  // Transfer FSM; every bus and memory output is registered.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_state        <= ST_IDLE;
      r_region       <= REG_CH_MAP;
      r_write        <= 1'b0;
      r_wdata        <= '0;
      r_strb         <= '0;
      r_word         <= '0;
      r_cnt          <= '0;
      r_pready       <= 1'b0;
      r_pslverr      <= 1'b0;
      r_prdata       <= '0;
      ch_map_addr_o  <= '0;
      ch_map_data_o  <= '0;
      ch_map_wen_o   <= '0;
      col_map_addr_o <= '0;
      col_map_data_o <= '0;
      col_map_wen_o  <= '0;
      ch_t_rw_addr_o <= '0;
      ch_t_rw_data_o <= '0;
      ch_t_rw_wen_o  <= 1'b0;
    end else begin
      r_pready      <= 1'b0;
      ch_map_wen_o  <= '0;
      col_map_wen_o <= '0;
      ch_t_rw_wen_o <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_setup) begin
            r_region <= w_reg;
            r_write  <= apb_pwrite_i;
            r_wdata  <= apb_pwdata_i;
            r_strb   <= apb_pstrb_i;
            r_word   <= w_word;
            r_cnt    <= '0;
            if (!w_legal) begin
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
              r_prdata  <= '0;
              r_state   <= ST_RESP;
            end else if (apb_pwrite_i && w_reg != REG_CH_T) begin
              r_pready  <= 1'b1;
              r_pslverr <= 1'b0;
              r_prdata  <= '0;
              r_state   <= ST_RESP;
              if (w_reg == REG_CH_MAP) begin
                ch_map_addr_o <= w_off;
                ch_map_data_o <= apb_pwdata_i;
                ch_map_wen_o  <= apb_pstrb_i;
              end else begin
                col_map_addr_o <= w_off;
                col_map_data_o <= apb_pwdata_i;
                col_map_wen_o  <= apb_pstrb_i;
              end
            end else begin
              r_pslverr <= 1'b0;
              r_state   <= ST_RD_WAIT;
              unique case (w_reg)
                REG_CH_MAP:  ch_map_addr_o  <= w_off;
                REG_COL_MAP: col_map_addr_o <= w_off;
                default:
                  ch_t_rw_addr_o <= w_entry[CH_T_ADDR_WIDTH-1:0];
              endcase
            end
          end
        end
        ST_RD_WAIT: begin
          if (!apb_psel_i) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == 2'(RD_LATENCY)) begin
            r_pready <= 1'b1;
            r_state  <= ST_RESP;
            unique case (r_region)
              REG_CH_MAP:  r_prdata <= ch_map_data_i;
              REG_COL_MAP: r_prdata <= col_map_data_i;
              default: begin
                if (r_write) begin
                  r_prdata       <= '0;
                  ch_t_rw_data_o <= merge_word(ch_t_rw_data_i,
                                      r_word, r_wdata, r_strb);
                  ch_t_rw_wen_o  <= |r_strb;
                end else begin
                  r_prdata <=
                    ch_t_rw_data_i[int'(r_word)*32 +: 32];
                end
              end
            endcase
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        ST_RESP: begin
          r_pslverr <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_vgachargen_bridge.sv
// Directed bench for apb_vgachargen_bridge with behavioural
// memories standing in for vgachargen at read latency 1.
module tb_apb_vgachargen_bridge;
  import vgachargen_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         psel, penable, pwrite;
  logic [13:0]  paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic         pready, pslverr;
  logic [31:0]  prdata;
  logic [9:0]   m_addr, c_addr;
  logic [31:0]  m_wd, c_wd, m_rd, c_rd;
  logic [3:0]   m_wen, c_wen;
  logic [CH_T_ADDR_WIDTH-1:0] t_addr;
  logic [CH_T_DATA_WIDTH-1:0] t_wd, t_rd;
  logic         t_wen;

  logic [31:0]  mem_map [0:599];
  logic [31:0]  mem_col [0:599];
  logic [127:0] mem_cht [0:127];
  logic         init_req;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_mw = 0, n_cw = 0, n_tw = 0;

  int          x_k;
  logic [31:0] x_rd;
  logic        x_err;
  logic [3:0]  x_mwen, x_cwen;
  logic        x_twen;
  logic [9:0]  x_maddr;

  apb_vgachargen_bridge dut (
    .sys_clk_i      (clk),
    .sys_rst_i      (rst),
    .apb_psel_i     (psel),
    .apb_penable_i  (penable),
    .apb_pwrite_i   (pwrite),
    .apb_paddr_i    (paddr),
    .apb_pwdata_i   (pwdata),
    .apb_pstrb_i    (pstrb),
    .apb_pready_o   (pready),
    .apb_prdata_o   (prdata),
    .apb_pslverr_o  (pslverr),
    .ch_map_addr_o  (m_addr),
    .ch_map_data_o  (m_wd),
    .ch_map_wen_o   (m_wen),
    .ch_map_data_i  (m_rd),
    .col_map_addr_o (c_addr),
    .col_map_data_o (c_wd),
    .col_map_wen_o  (c_wen),
    .col_map_data_i (c_rd),
    .ch_t_rw_addr_o (t_addr),
    .ch_t_rw_data_o (t_wd),
    .ch_t_rw_wen_o  (t_wen),
    .ch_t_rw_data_i (t_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: byte writes, one-edge read latency.
  always @(posedge clk) begin
    if (init_req) begin
      mem_col[598] <= 32'h11223344;
      mem_cht[5]   <= 128'h00112233_44556677_8899AABB_CCDDEEFF;
    end
    for (int b = 0; b < 4; b++) begin
      if (m_wen[b]) mem_map[m_addr][b*8 +: 8] <= m_wd[b*8 +: 8];
      if (c_wen[b]) mem_col[c_addr][b*8 +: 8] <= c_wd[b*8 +: 8];
    end
    if (t_wen) mem_cht[t_addr] <= t_wd;
    m_rd <= mem_map[m_addr];
    c_rd <= mem_col[c_addr];
    t_rd <= mem_cht[t_addr];
  end

  always @(negedge clk) begin
    if (m_wen != 4'h0) n_mw <= n_mw + 1;
    if (c_wen != 4'h0) n_cw <= n_cw + 1;
    if (t_wen) n_tw <= n_tw + 1;
  end

  // One APB transfer; entered and left just after a posedge.
  task automatic apb(input logic w, input logic [13:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    logic done;
    psel = 1'b1; penable = 1'b0; pwrite = w;
    paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1'b1;
    x_k = 1;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (pready) begin
        done = 1'b1;
      end else if (x_k >= 20) begin
        checks++; failures++;
        $display("FAIL timeout addr=%h no pready", a);
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        x_k++;
      end
    end
    x_rd = prdata; x_err = pslverr;
    x_mwen = m_wen; x_cwen = c_wen; x_twen = t_wen;
    x_maddr = m_addr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; init_req = 1'b1;
    psel = 0; penable = 0; pwrite = 0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; init_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({pready, pslverr, prdata, m_wen, c_wen, t_wen,
         m_addr, t_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs pready=%b err=%b rd=%h",
               pready, pslverr, prdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_map_write();
    int mw0;
    mw0 = n_mw;
    apb(1'b1, 14'h0004, 32'hA1B2C3D4, 4'hF);
    checks++;
    if (x_mwen !== 4'hF || x_maddr !== 10'd1 || x_k != 1) begin
      failures++;
      $display("FAIL map_write wen=%h addr=%0d k=%0d want F 1 1",
               x_mwen, x_maddr, x_k);
    end
    checks++;
    if (x_rd !== 32'h0 || x_err !== 1'b0 || n_mw - mw0 != 1) begin
      failures++;
      $display("FAIL map_write_resp rd=%h err=%b pulses=%0d",
               x_rd, x_err, n_mw - mw0);
    end
    apb(1'b0, 14'h0004, 32'h0, 4'h0);
    checks++;
    if (x_rd !== 32'hA1B2C3D4 || x_k != 3) begin
      failures++;
      $display("FAIL map_read rd=%h k=%0d want a1b2c3d4 3",
               x_rd, x_k);
    end
    mw0 = n_mw;
    apb(1'b1, 14'h0004, 32'h0, 4'h0);
    apb(1'b0, 14'h0004, 32'h0, 4'h0);
    checks++;
    if (n_mw != mw0 || x_rd !== 32'hA1B2C3D4) begin
      failures++;
      $display("FAIL map_strb0 pulses=%0d rd=%h want 0 a1b2c3d4",
               n_mw - mw0, x_rd);
    end
  endtask

  task automatic test_col_map();
    int mw0, cw0;
    mw0 = n_mw; cw0 = n_cw;
    apb(1'b1, 14'h1958, 32'h0000_5500, 4'b0010);
    checks++;
    if (x_cwen !== 4'b0010 || n_cw - cw0 != 1 || n_mw != mw0) begin
      failures++;
      $display("FAIL col_write cwen=%b cp=%0d mp=%0d want 0010 1 0",
               x_cwen, n_cw - cw0, n_mw - mw0);
    end
    apb(1'b0, 14'h1958, 32'h0, 4'h0);
    checks++;
    if (x_rd !== 32'h11225544) begin
      failures++;
      $display("FAIL col_read rd=%h want 11225544", x_rd);
    end
  endtask

  task automatic test_ch_t();
    int tw0;
    tw0 = n_tw;
    apb(1'b1, 14'h2054, 32'hDEADBEEF, 4'h3);
    checks++;
    if (x_twen !== 1'b1 || x_k != 3 || n_tw - tw0 != 1) begin
      failures++;
      $display("FAIL cht_write wen=%b k=%0d pulses=%0d want 1 3 1",
               x_twen, x_k, n_tw - tw0);
    end
    checks++;
    if (mem_cht[5] !== 128'h00112233_44556677_8899BEEF_CCDDEEFF)
    begin
      failures++;
      $display("FAIL cht_entry got=%h", mem_cht[5]);
    end
    apb(1'b0, 14'h2054, 32'h0, 4'h0);
    checks++;
    if (x_rd !== 32'h8899BEEF || x_k != 3) begin
      failures++;
      $display("FAIL cht_read1 rd=%h k=%0d want 8899beef 3",
               x_rd, x_k);
    end
    apb(1'b0, 14'h2050, 32'h0, 4'h0);
    checks++;
    if (x_rd !== 32'hCCDDEEFF) begin
      failures++;
      $display("FAIL cht_read0 rd=%h want ccddeeff", x_rd);
    end
  endtask

  task automatic test_errors();
    logic [13:0] addrs [3];
    int p0;
    addrs[0] = 14'h0960;
    addrs[1] = 14'h3000;
    addrs[2] = 14'h2800;
    for (int i = 0; i < 3; i++) begin
      p0 = n_mw + n_cw + n_tw;
      apb(1'b1, addrs[i], 32'hFFFFFFFF, 4'hF);
      checks++;
      if (x_err !== 1'b1 || x_k != 1 || x_rd !== 32'h0 ||
          n_mw + n_cw + n_tw != p0) begin
        failures++;
        $display("FAIL error_%0d err=%b k=%0d rd=%h pulses=%0d",
                 i, x_err, x_k, x_rd, n_mw + n_cw + n_tw - p0);
      end
    end
  endtask

  task automatic test_abort();
    int seen;
    seen = 0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0;
    paddr = 14'h0004;
    @(posedge clk); #1;
    penable = 1'b1; psel = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (pready) seen++;
    end
    penable = 1'b0;
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort pready_cycles=%0d want 0", seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int tw0;
    tw0 = n_tw;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 14'h2054; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    checks++;
    if ({pready, pslverr, prdata, m_wen, c_wen, t_wen, m_addr,
         c_addr, t_addr, m_wd, c_wd, t_wd} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs pready=%b twen=%b taddr=%h",
               pready, t_wen, t_addr);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (n_tw != tw0 ||
        mem_cht[5] !== 128'h00112233_44556677_8899BEEF_CCDDEEFF)
    begin
      failures++;
      $display("FAIL reset_mid_drop pulses=%0d entry=%h",
               n_tw - tw0, mem_cht[5]);
    end
    apb(1'b1, 14'h0010, 32'h5A5A1234, 4'hF);
    apb(1'b0, 14'h0010, 32'h0, 4'h0);
    checks++;
    if (x_rd !== 32'h5A5A1234 || x_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_recover rd=%h err=%b want 5a5a1234 0",
               x_rd, x_err);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [7:0]  b;
    logic [31:0] v;
    c0 = cyc;
    for (int i = 0; i < 600; i++) begin
      b = i[7:0];
      apb(1'b1, 14'(i * 4), {4{b}}, 4'hF);
    end
    checks++;
    if (cyc - c0 != 1200) begin
      failures++;
      $display("FAIL sweep_write_cycles got=%0d want 1200", cyc - c0);
    end
    c0 = cyc;
    for (int i = 0; i < 600; i++) begin
      b = i[7:0];
      v = {4{b}};
      apb(1'b0, 14'(i * 4), 32'h0, 4'h0);
      checks++;
      if (x_rd !== v) begin
        failures++;
        $display("FAIL sweep_read word=%0d got=%h want=%h",
                 i, x_rd, v);
      end
    end
    checks++;
    if (cyc - c0 != 2400) begin
      failures++;
      $display("FAIL sweep_read_cycles got=%0d want 2400", cyc - c0);
    end
  endtask

  initial begin
    test_reset();
    test_map_write();
    test_col_map();
    test_ch_t();
    test_errors();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_vgachargen_bridge.md
# apb_vgachargen_bridge

APB3 responder that exposes the vgachargen character map, colour map and character table to a system bus. It decodes APB transfers into the synchronous memory ports of `vgachargen`: write enables, addresses and data. It inserts wait states for read latency, and performs read-modify-write for sub-word writes to the wide character table. It sits between the bus interconnect and `vgachargen`, in the `sys_clk_i` domain.

## Interface

Parameters:
- `APB_ADDR_WIDTH`, default 14: byte-address width. `paddr[13:12]` is the region select.
- `RD_LATENCY`, default 1: clock edges from the memory address being presented until `*_data_i` is valid. Legal range is 1–3.

Clock and reset:
- Clock and reset: one clock, `sys_clk_i`; reset `sys_rst_i` is synchronous and active-high.

APB ports:
- `apb_psel_i`, in, 1: transfer select.
- `apb_penable_i`, in, 1: access phase.
- `apb_pwrite_i`, in, 1: 1 = write.
- `apb_paddr_i`, in, `APB_ADDR_WIDTH`: byte address. Bits [1:0] are ignored.
- `apb_pwdata_i`, in, 32: write data.
- `apb_pstrb_i`, in, 4: byte strobes.
- `apb_pready_o`, out, 1: transfer completes this cycle.
- `apb_prdata_o`, out, 32: read data. Valid when pready is high for a read.
- `apb_pslverr_o`, out, 1: error response. Valid with pready.

Memory ports:
- `ch_map_addr_o`, out, 10: character-map word address (0..599).
- `ch_map_data_o`, out, 32: character-map write data, 4 bytes.
- `ch_map_wen_o`, out, 4: character-map per-byte write enable.
- `ch_map_data_i`, in, 32: character-map read data.
- `col_map_addr_o`, `col_map_data_o`, `col_map_wen_o`, `col_map_data_i`: colour map, same widths as the character-map ports.
- `ch_t_rw_addr_o`, out, `CH_T_ADDR_WIDTH`: character-table entry index.
- `ch_t_rw_data_o`, out, `CH_T_DATA_WIDTH`: character-table write data.
- `ch_t_rw_wen_o`, out, 1: full-entry write enable.
- `ch_t_rw_data_i`, in, `CH_T_DATA_WIDTH`: character-table read data.

## Operation

Region decode on `paddr[13:12]`; `off = paddr[11:2]`:
- Region 0, `ch_map`: word = `off`; legal if `off < 600`.
- Region 1, `col_map`: same rule.
- Region 2, `ch_t`: entry = `off / CH_T_WORDS`, word = `off % CH_T_WORDS`; legal if entry < `2**CH_T_ADDR_WIDTH`.
- Region 3, or any illegal offset: `pslverr=1`, and no memory enable is asserted.

State machine, with states IDLE, RD_WAIT, RESP:
- IDLE:
  - `psel & !penable`: register address, region, pwrite, pwdata and pstrb.
  - Map write: drive addr, data and `wen=pstrb` next cycle, then go to RESP.
  - Read, or any `ch_t` access: drive addr, then go to RD_WAIT.
  - Error: go to RESP with pslverr.
- RD_WAIT:
  - Count `RD_LATENCY` edges, then capture the selected `*_data_i`.
  - `ch_t` read: select 32-bit word `word`.
  - Map read: return the full word.
  - `ch_t` write: byte-merge `pwdata` under `pstrb` into the captured entry at word `word`. Drive the merged entry with `ch_t_rw_wen_o=1` for exactly one cycle, coincident with RESP.
  - Go to RESP.
- RESP:
  - `pready=1` for one cycle, with prdata and pslverr valid.
  - Return to IDLE.

Edge cases:
- Write with `pstrb=4'b0000`: completes OKAY. Map regions assert no enable; `ch_t` skips the write-back.
- Only one enable is ever active, and only in the target region. All `wen` outputs are 0 in every other cycle.
- prdata holds its last value between transfers; it is 0 after writes and errors.
- `psel` low in RD_WAIT (protocol violation): abort to IDLE, with no write-back and no pready.
- Reset at any point:
  - Go to IDLE.
  - All outputs are 0, including `wen`, addresses, data and pready.
  - A pending `ch_t` write-back is dropped.

## Timing

Phase labels: the setup phase is cycle S; access cycles are A1, A2, and so on.
- Map write:
  - addr, data and `wen` are registered at the end of S and valid in A1.
  - `pready` is high in A1: zero wait states, 2-cycle transfer.
- Error:
  - `pready` and `pslverr` are high in A1.
- Map or `ch_t` read:
  - addr is valid from A1.
  - data is captured at the end of A(1+`RD_LATENCY`).
  - `pready` is high in A(2+`RD_LATENCY`). This is A3 at default latency.
- `ch_t` write:
  - `ch_t_rw_wen_o` and `pready` are both high in A(2+`RD_LATENCY`).
- Back-to-back transfers: a new setup phase is accepted in the cycle after pready, with no idle cycle required.
- All outputs are registered. There is no combinational path from APB inputs to memory ports.

## Structure

- Package `vgachargen_pkg` gains:
  - `MAP_WORDS = 600`;
  - `CH_T_WORDS = CH_T_DATA_WIDTH/32`, where `CH_T_DATA_WIDTH` must be a multiple of 32;
  - a region enum `{REG_CH_MAP, REG_COL_MAP, REG_CH_T, REG_RSVD}`;
  - a byte-merge function `merge_word(entry, word_idx, wdata, strb)`.
- The FSM state enum is local to the module. No sub-module is needed.

## Test plan

- Write `ch_map` at 0x0004 with pwdata 0xA1B2C3D4 and pstrb 0xF:
  - `ch_map_wen_o=4'hF` and `ch_map_addr_o=1` in A1, pready in A1.
  - A subsequent read of 0x0004 returns 0xA1B2C3D4 with pready in A3.
- Write `col_map` at 0x1958 (word 598) with pstrb 4'b0010 and data 0x0000_5500:
  - only `col_map_wen_o=4'b0010`.
  - Reading word 598 returns byte1=0x55 and the other bytes unchanged.
- Write `ch_t` entry 5, word 1 (addr 0x2054 for `CH_T_WORDS`=4) with 0xDEADBEEF and pstrb 0x3:
  - one `ch_t_rw_wen_o` pulse.
  - The written entry changes only bits [47:32], to 0xBEEF.
  - pready in A3.
- Accesses at 0x0960 (word 600), 0x3000 (region 3) and a `ch_t` entry past the end:
  - `pslverr=1`, pready in A1, all enables stay 0.
- Assert `sys_rst_i` in A2 of a `ch_t` write:
  - no `wen` pulse, all outputs 0 the next cycle.
  - A following clean write/read to `ch_map` succeeds.
- Sweep all 600 `ch_map` words back-to-back, each with value `{4{i[7:0]}}`, then read them all back: every word matches and no idle cycles are inserted.
